// File: rtl/mult_arbiter_pkg.sv
// Shared definitions for the multiplier arbiter: sequencer state encoding and default sizes.
package mult_arbiter_pkg;

  localparam int DEF_W    = 8;
  localparam int DEF_NREQ = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_SETTLE,
    ST_WAIT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/mult_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request strictly after ptr, wrapping modulo NREQ.
module mult_arbiter_rr_pick
  import mult_arbiter_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] winner,
  output logic [IW-1:0]   idx
);

  always_comb begin
    int              cand;
    logic            found;
    logic [NREQ-1:0] shifted;
    winner  = '0;
    idx     = '0;
    found   = 1'b0;
    cand    = 0;
    shifted = '0;
    // i starts at 1 so the requester at ptr (last served) is checked last
    for (int i = 1; i <= NREQ; i++) begin
      cand    = (int'(ptr) + i) % NREQ;
      shifted = req >> cand;
      if (!found && shifted[0]) begin
        found  = 1'b1;
        winner = NREQ'(1) << cand;
        idx    = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin sequencer sharing one iterative multiplier among NREQ requesters.
// Operands are latched at grant; the product returns with a one-cycle done strobe.
module mult_arbiter
  import mult_arbiter_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int W    = DEF_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] a_in,
  input  logic [NREQ*W-1:0] b_in,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [2*W-1:0]    y,
  output logic              busy,
  output logic              mul_start,
  output logic [W-1:0]      mul_a,
  output logic [W-1:0]      mul_b,
  input  logic              mul_busy,
  input  logic [2*W-1:0]    mul_y
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t          state, state_nx;
  logic [IW-1:0]   ptr;
  logic [NREQ-1:0] win;
  logic [IW-1:0]   win_idx;
  logic [W-1:0]    sel_a, sel_b;
  logic            capture;
  logic            finish;

  mult_arbiter_rr_pick #(.NREQ(NREQ)) u_pick (
    .req    (req),
    .ptr    (ptr),
    .winner (win),
    .idx    (win_idx)
  );

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win[i]) begin
        sel_a = a_in[i*W +: W];
        sel_b = b_in[i*W +: W];
      end
    end
  end

  assign capture = (state == ST_IDLE) && (|req);
  assign finish  = (state == ST_WAIT) && !mul_busy;

  // SETTLE exists because the multiplier raises busy one cycle after start
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (|req) state_nx = ST_LAUNCH;
      ST_LAUNCH: state_nx = ST_SETTLE;
      ST_SETTLE: state_nx = ST_WAIT;
      ST_WAIT:   if (!mul_busy) state_nx = ST_DONE;
      ST_DONE:   state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt   <= '0;
      ptr   <= IW'(NREQ - 1);
      mul_a <= '0;
      mul_b <= '0;
      y     <= '0;
    end else begin
      if (capture) begin
        gnt   <= win;
        ptr   <= win_idx;
        mul_a <= sel_a;
        mul_b <= sel_b;
      end
      if (finish) y <= mul_y;
      if (state == ST_DONE) gnt <= '0;
    end
  end

  assign mul_start = (state == ST_LAUNCH);
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE) ? gnt : '0;

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter with a behavioural iterative multiplier (busy one cycle after start).
module tb_mult_arbiter;

  localparam int NREQ    = 4;
  localparam int W       = 8;
  localparam int MUL_LAT = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*W-1:0] a_in = '0;
  logic [NREQ*W-1:0] b_in = '0;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic [2*W-1:0]    y;
  logic              busy;
  logic              mul_start;
  logic [W-1:0]      mul_a;
  logic [W-1:0]      mul_b;
  logic              mul_busy;
  logic [2*W-1:0]    mul_y;

  int total = 0;
  int bad   = 0;

  mult_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .a_in      (a_in),
    .b_in      (b_in),
    .gnt       (gnt),
    .done      (done),
    .y         (y),
    .busy      (busy),
    .mul_start (mul_start),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_busy  (mul_busy),
    .mul_y     (mul_y)
  );

  always #5 clk = ~clk;

  // Behavioural shared multiplier
  logic [W-1:0] m_a, m_b;
  int           m_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_busy <= 1'b0;
      mul_y    <= '0;
      m_cnt    <= 0;
      m_a      <= '0;
      m_b      <= '0;
    end else if (mul_start) begin
      mul_busy <= 1'b1;
      m_cnt    <= MUL_LAT;
      m_a      <= mul_a;
      m_b      <= mul_b;
    end else if (mul_busy) begin
      if (m_cnt == 1) begin
        mul_busy <= 1'b0;
        mul_y    <= m_a * m_b;
      end
      m_cnt <= m_cnt - 1;
    end
  end

  // Event logs
  logic [NREQ-1:0] done_log[$];
  logic [2*W-1:0]  y_log[$];
  int              start_cnt = 0;

  always @(negedge clk) begin
    if (rst_n && done != '0) begin
      done_log.push_back(done);
      y_log.push_back(y);
    end
  end

  always @(posedge clk) begin
    if (rst_n && mul_start) start_cnt++;
  end

  task automatic clear_logs();
    done_log.delete();
    y_log.delete();
    start_cnt = 0;
  endtask

  task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    a_in[i*W +: W] = a;
    b_in[i*W +: W] = b;
  endtask

  task automatic wait_dones(input int n, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk); #1;
      if (done_log.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_gnt(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      if (gnt != '0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_logs();
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    total++;
    if (gnt !== 4'b0 || done !== 4'b0 || y !== 16'd0 || busy !== 1'b0 ||
        mul_start !== 1'b0 || mul_a !== 8'd0 || mul_b !== 8'd0) begin
      bad++;
      $display("FAIL reset_outputs got gnt=%b done=%b y=%0d busy=%b start=%b a=%0d b=%0d want all zero",
               gnt, done, y, busy, mul_start, mul_a, mul_b);
    end
  endtask

  task automatic test_single();
    bit ok;
    clear_logs();
    set_ops(2, 8'd13, 8'd11);
    @(negedge clk);
    req = 4'b0100;
    wait_gnt(ok);
    total++;
    if (!ok || gnt !== 4'b0100 || mul_a !== 8'd13 || mul_b !== 8'd11) begin
      bad++;
      $display("FAIL single_grant got ok=%b gnt=%b a=%0d b=%0d want gnt=0100 a=13 b=11", ok, gnt, mul_a, mul_b);
    end
    wait_dones(1, ok);
    req = '0;
    repeat (6) @(negedge clk);
    total++;
    if (!ok || done_log.size() != 1) begin
      bad++;
      $display("FAIL single_done_count got %0d want 1", done_log.size());
    end else begin
      total++;
      if (done_log[0] !== 4'b0100 || y_log[0] !== 16'd143) begin
        bad++;
        $display("FAIL single_result got done=%b y=%0d want done=0100 y=143", done_log[0], y_log[0]);
      end
    end
    total++;
    if (start_cnt != 1 || busy !== 1'b0 || y !== 16'd143) begin
      bad++;
      $display("FAIL single_start got starts=%0d busy=%b y=%0d want starts=1 busy=0 y=143", start_cnt, busy, y);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    clear_logs();
    set_ops(2, 8'd5, 8'd6);
    @(negedge clk);
    req = 4'b0100;
    wait_gnt(ok);
    repeat (3) @(posedge clk);
    #2;
    total++;
    if (busy !== 1'b1 || mul_busy !== 1'b1) begin
      bad++;
      $display("FAIL midop_busy got busy=%b mul_busy=%b want 1 1", busy, mul_busy);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (gnt !== 4'b0 || done !== 4'b0 || busy !== 1'b0 || y !== 16'd0 || mul_start !== 1'b0) begin
      bad++;
      $display("FAIL async_reset got gnt=%b done=%b busy=%b y=%0d start=%b want zeros",
               gnt, done, busy, y, mul_start);
    end
    req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    clear_logs();
    set_ops(0, 8'd7, 8'd3);
    set_ops(3, 8'd1, 8'd1);
    @(negedge clk);
    req = 4'b1001;
    wait_gnt(ok);
    total++;
    if (!ok || gnt !== 4'b0001) begin
      bad++;
      $display("FAIL reset_ptr got gnt=%b want 0001", gnt);
    end
    req = 4'b0000;
    wait_dones(1, ok);
    total++;
    if (!ok || done_log[0] !== 4'b0001 || y_log[0] !== 16'd21) begin
      bad++;
      $display("FAIL reset_next_result got ok=%b done=%b y=%0d want done=0001 y=21",
               ok, ok ? done_log[0] : 4'b0, ok ? y_log[0] : 16'd0);
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    logic [NREQ-1:0] exp_done[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [2*W-1:0]  exp_y[5]    = '{16'd10, 16'd20, 16'd30, 16'd40, 16'd10};
    apply_reset();
    for (int i = 0; i < NREQ; i++) set_ops(i, 8'(i + 1), 8'd10);
    @(negedge clk);
    req = 4'b1111;
    wait_dones(5, ok);
    req = '0;
    repeat (8) @(negedge clk);
    total++;
    if (!ok || done_log.size() != 5) begin
      bad++;
      $display("FAIL rr_count got %0d want 5", done_log.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        total++;
        if (done_log[k] !== exp_done[k] || y_log[k] !== exp_y[k]) begin
          bad++;
          $display("FAIL rr_order[%0d] got done=%b y=%0d want done=%b y=%0d",
                   k, done_log[k], y_log[k], exp_done[k], exp_y[k]);
        end
      end
    end
  endtask

  task automatic test_extremes();
    bit ok;
    clear_logs();
    set_ops(0, 8'd255, 8'd255);
    @(negedge clk);
    req = 4'b0001;
    wait_dones(1, ok);
    req = '0;
    total++;
    if (!ok || y_log[0] !== 16'd65025) begin
      bad++;
      $display("FAIL max_product got y=%0d want 65025", ok ? y_log[0] : 16'd0);
    end
    clear_logs();
    set_ops(0, 8'd0, 8'd200);
    @(negedge clk);
    req = 4'b0001;
    wait_dones(1, ok);
    req = '0;
    total++;
    if (!ok || y_log[0] !== 16'd0 || y !== 16'd0) begin
      bad++;
      $display("FAIL zero_product got y=%0d want 0", y);
    end
  endtask

  task automatic test_operand_change();
    bit ok;
    clear_logs();
    set_ops(3, 8'd9, 8'd9);
    @(negedge clk);
    req = 4'b1000;
    wait_gnt(ok);
    set_ops(3, 8'd100, 8'd9);
    wait_dones(1, ok);
    req = '0;
    total++;
    if (!ok || y_log[0] !== 16'd81 || mul_a !== 8'd9) begin
      bad++;
      $display("FAIL latched_operand got y=%0d mul_a=%0d want y=81 mul_a=9", ok ? y_log[0] : 16'd0, mul_a);
    end
  endtask

  task automatic test_drop_after_grant();
    bit ok;
    repeat (2) @(negedge clk);
    clear_logs();
    set_ops(1, 8'd6, 8'd7);
    set_ops(3, 8'd2, 8'd50);
    @(negedge clk);
    req = 4'b1010;
    wait_gnt(ok);
    total++;
    if (!ok || gnt !== 4'b0010) begin
      bad++;
      $display("FAIL drop_first_grant got gnt=%b want 0010", gnt);
    end
    req = 4'b1000;
    wait_dones(2, ok);
    req = '0;
    repeat (8) @(negedge clk);
    total++;
    if (!ok || done_log.size() != 2) begin
      bad++;
      $display("FAIL drop_done_count got %0d want 2", done_log.size());
    end else begin
      total++;
      if (done_log[0] !== 4'b0010 || y_log[0] !== 16'd42 ||
          done_log[1] !== 4'b1000 || y_log[1] !== 16'd100) begin
        bad++;
        $display("FAIL drop_sequence got %b/%0d %b/%0d want 0010/42 1000/100",
                 done_log[0], y_log[0], done_log[1], y_log[1]);
      end
    end
    total++;
    if (start_cnt != 2) begin
      bad++;
      $display("FAIL drop_starts got %0d want 2", start_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_reset_mid();
    test_round_robin();
    test_extremes();
    test_operand_change();
    test_drop_after_grant();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
